// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, instruction codes, register names, write-back FSM states.
package y86_pkg;

   localparam int unsigned STAT_W  = 3;
   localparam int unsigned ICODE_W = 4;
   localparam int unsigned REG_W   = 4;

   // Pipeline status codes
   localparam logic [STAT_W-1:0] SAOK = 3'd1;
   localparam logic [STAT_W-1:0] SHLT = 3'd2;
   localparam logic [STAT_W-1:0] SADR = 3'd3;
   localparam logic [STAT_W-1:0] SINS = 3'd4;

   // Instruction codes
   localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
   localparam logic [ICODE_W-1:0] INOP    = 4'h1;
   localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
   localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
   localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
   localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
   localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
   localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
   localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
   localparam logic [ICODE_W-1:0] IRET    = 4'h9;
   localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
   localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

   // Register names
   localparam logic [REG_W-1:0] RRSP  = 4'h4;
   localparam logic [REG_W-1:0] RNONE = 4'hF;

   // Write-back stage state
   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } wb_state_e;

   // True when a status lets the instruction in W commit its results
   function automatic logic stat_commits(input logic [STAT_W-1:0] stat);
      return stat == SAOK;
   endfunction

endpackage

// File: rtl/wb_read_port.sv
// One register-file read port: index decode with range check, 0 for RNONE/out-of-range.
// Optional same-cycle write-through from the committing W instruction when WB_BYPASS_EN is defined.
module wb_read_port
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NUM_REGS = 15,
   parameter int unsigned ADDR_W   = 4
) (
   input  logic [ADDR_W-1:0]          i_addr,
   input  logic [NUM_REGS*DATA_W-1:0] i_regs,
`ifdef WB_BYPASS_EN
   input  logic                       i_byp_e_en,
   input  logic [ADDR_W-1:0]          i_byp_e_addr,
   input  logic [DATA_W-1:0]          i_byp_e_data,
   input  logic                       i_byp_m_en,
   input  logic [ADDR_W-1:0]          i_byp_m_addr,
   input  logic [DATA_W-1:0]          i_byp_m_data,
`endif
   output logic [DATA_W-1:0]          o_rd_data_c
);

   logic [DATA_W-1:0] w_stored;

   // Stored-value mux; RNONE and indices past the file never match and fall through to 0
   always_comb begin
      w_stored = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i_addr == ADDR_W'(i)) begin
            w_stored = i_regs[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef WB_BYPASS_EN
   // Write-through: M has priority over E, matching the commit ordering
   always_comb begin
      o_rd_data_c = w_stored;
      if (i_byp_m_en && (i_byp_m_addr == i_addr)) begin
         o_rd_data_c = i_byp_m_data;
      end else if (i_byp_e_en && (i_byp_e_addr == i_addr)) begin
         o_rd_data_c = i_byp_e_data;
      end
   end
`else
   // Stored value only; decode forwards from W on its own
   always_comb begin
      o_rd_data_c = w_stored;
   end
`endif

endmodule

// File: rtl/wb_regfile_ctrl.sv
// Y86 write-back stage: register file, commit gating on W_stat, halt latch and retire counter.
// Optional macro WB_BYPASS_EN: read ports see same-cycle commits (reg_dump never does).
module wb_regfile_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NUM_REGS = 15,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0]                 W_stat,
   input  logic [3:0]                 W_icode,
   input  logic [ADDR_W-1:0]          W_dstE,
   input  logic [ADDR_W-1:0]          W_dstM,
   input  logic [DATA_W-1:0]          W_valE,
   input  logic [DATA_W-1:0]          W_valM,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_REGS*DATA_W-1:0] reg_dump,
   output logic                       halted,
   output logic [2:0]                 halt_stat,
   output logic [CNT_W-1:0]           retired
);

   localparam logic [ADDR_W-1:0] L_RNONE = '1;
   localparam logic [ADDR_W:0]   L_NREGS = (ADDR_W+1)'(NUM_REGS);

   wb_state_e         r_state;
   wb_state_e         w_state_nxt;
   logic              w_commit;
   logic              w_halt_load;
   logic              w_dste_ok;
   logic              w_dstm_ok;
   logic              w_we_e;
   logic              w_we_m;
   logic              w_count;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              r_halted;
   logic [2:0]        r_halt_stat;
   logic [CNT_W-1:0]  r_retired;

   // Destination validity: not RNONE and inside the implemented file
   always_comb begin
      w_dste_ok = (W_dstE != L_RNONE) && ({1'b0, W_dstE} < L_NREGS);
      w_dstm_ok = (W_dstM != L_RNONE) && ({1'b0, W_dstM} < L_NREGS);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and commit decision; the halting instruction itself never commits
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_halt_load = 1'b0;
      case (r_state)
         RUN: begin
            if (stat_commits(W_stat)) begin
               w_commit = 1'b1;
            end else begin
               w_state_nxt = HALTED;
               w_halt_load = 1'b1;
            end
         end
         HALTED: begin
            w_state_nxt = HALTED;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   // Write enables and retire qualifier (bubbles and HALT icode do not count)
   always_comb begin
      w_we_e  = w_commit && w_dste_ok;
      w_we_m  = w_commit && w_dstm_ok;
      w_count = w_commit && (W_icode != INOP) && (W_icode != IHALT);
   end

   // Register storage; M wins when both ports target the same register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_we_m && (W_dstM == ADDR_W'(i))) begin
               r_regs[i] <= W_valM;
            end else if (w_we_e && (W_dstE == ADDR_W'(i))) begin
               r_regs[i] <= W_valE;
            end
         end
      end
   end

   // Halt flag and status snapshot, loaded only on the RUN->HALTED edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_halted    <= 1'b0;
         r_halt_stat <= 3'd0;
      end else if (w_halt_load) begin
         r_halted    <= 1'b1;
         r_halt_stat <= W_stat;
      end
   end

   // Saturating retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retired <= '0;
      end else if (w_count && (r_retired != '1)) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign halted    = r_halted;
   assign halt_stat = r_halt_stat;
   assign retired   = r_retired;

   // Flat debug dump of stored state
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
      assign reg_dump[g*DATA_W +: DATA_W] = r_regs[g];
   end

   // Read ports
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      wb_read_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W)
      ) u_port (
         .i_addr       (rd_addr[p*ADDR_W +: ADDR_W]),
         .i_regs       (reg_dump),
`ifdef WB_BYPASS_EN
         .i_byp_e_en   (w_we_e),
         .i_byp_e_addr (W_dstE),
         .i_byp_e_data (W_valE),
         .i_byp_m_en   (w_we_m),
         .i_byp_m_addr (W_dstM),
         .i_byp_m_data (W_valM),
`endif
         .o_rd_data_c  (rd_data[p*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_wb_regfile_ctrl.sv
// Self-checking bench for wb_regfile_ctrl: scoreboard of expectations drained by each scenario task.
module tb_wb_regfile_ctrl;
   import y86_pkg::*;

   localparam int unsigned DW = 64;
   localparam int unsigned NR = 15;
   localparam int unsigned AW = 4;
   localparam int unsigned NP = 2;

   localparam int K_REG  = 0;
   localparam int K_RD   = 1;
   localparam int K_HALT = 2;
   localparam int K_HST  = 3;
   localparam int K_RET  = 4;
   localparam int K_RSAT = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        W_stat;
   logic [3:0]        W_icode;
   logic [AW-1:0]     W_dstE, W_dstM;
   logic [DW-1:0]     W_valE, W_valM;
   logic [NP*AW-1:0]  rd_addr;
   logic [NP*DW-1:0]  rd_data, rd_data_s;
   logic [NR*DW-1:0]  reg_dump, reg_dump_s;
   logic              halted, halted_s;
   logic [2:0]        halt_stat, halt_stat_s;
   logic [31:0]       retired;
   logic [2:0]        retired_sat;

   typedef struct {
      int          kind;
      int          idx;
      logic [63:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   wb_regfile_ctrl #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NP), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .W_valE(W_valE), .W_valM(W_valM), .rd_addr(rd_addr), .rd_data(rd_data), .reg_dump(reg_dump),
      .halted(halted), .halt_stat(halt_stat), .retired(retired)
   );

   wb_regfile_ctrl #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NP), .CNT_W(3)) u_sat (
      .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .W_valE(W_valE), .W_valM(W_valM), .rd_addr(rd_addr), .rd_data(rd_data_s), .reg_dump(reg_dump_s),
      .halted(halted_s), .halt_stat(halt_stat_s), .retired(retired_sat)
   );

   function automatic logic [63:0] observe(input int kind, input int idx);
      case (kind)
         K_REG:   return reg_dump[idx*DW +: DW];
         K_RD:    return rd_data[idx*DW +: DW];
         K_HALT:  return 64'(halted);
         K_HST:   return 64'(halt_stat);
         K_RET:   return 64'(retired);
         K_RSAT:  return 64'(retired_sat);
         default: return 64'hDEAD_DEAD_DEAD_DEAD;
      endcase
   endfunction

   task automatic push(input int kind, input int idx, input logic [63:0] exp, input string name);
      exp_t e;
      e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [AW-1:0] de,
                        input logic [DW-1:0] ve, input logic [AW-1:0] dm, input logic [DW-1:0] vm);
      W_stat = st; W_icode = ic; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
   endtask

   task automatic idle();
      drive(SAOK, INOP, RNONE, 64'd0, RNONE, 64'd0);
   endtask

   // Drive one W instruction at a falling edge and return at the next falling edge
   task automatic step(input logic [2:0] st, input logic [3:0] ic, input logic [AW-1:0] de,
                       input logic [DW-1:0] ve, input logic [AW-1:0] dm, input logic [DW-1:0] vm);
      drive(st, ic, de, ve, dm, vm);
      @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e; logic [63:0] obs;
      for (int i = 0; i < int'(NR); i++) push(K_REG, i, 64'd0, "reset_reg");
      push(K_HALT, 0, 64'd0, "reset_halted");
      push(K_HST, 0, 64'd0, "reset_halt_stat");
      push(K_RET, 0, 64'd0, "reset_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      step(SAOK, IIRMOVQ, 4'd1, 64'hAA, RNONE, 64'd0);
      idle();
      push(K_REG, 1, 64'hAA, "preload_reg1");
      push(K_RET, 0, 64'd1, "preload_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      // Assert reset between edges while a write is pending
      step(SAOK, IIRMOVQ, 4'd6, 64'h66, RNONE, 64'd0);
      @(posedge clk); #2 rst = 1'b1; #1;
      push(K_REG, 1, 64'd0, "async_reg1");
      push(K_REG, 6, 64'd0, "async_reg6");
      push(K_HALT, 0, 64'd0, "async_halted");
      push(K_RET, 0, 64'd0, "async_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      idle();
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_irmovq();
      exp_t e; logic [63:0] obs;
      step(SAOK, IIRMOVQ, 4'd2, 64'h1234, RNONE, 64'd0);
      idle();
      push(K_REG, 2, 64'h1234, "irmovq_reg2");
      push(K_RET, 0, 64'd1, "irmovq_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
   endtask

   task automatic test_popq();
      exp_t e; logic [63:0] obs;
      step(SAOK, IPOPQ, RRSP, 64'h100, RRSP, 64'hBEEF);
      push(K_REG, 4, 64'hBEEF, "popq_rsp_m_wins");
      push(K_RET, 0, 64'd2, "popq_rsp_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      step(SAOK, IPOPQ, RRSP, 64'h108, 4'd0, 64'hCAFE);
      idle();
      push(K_REG, 4, 64'h108, "popq_rax_rsp");
      push(K_REG, 0, 64'hCAFE, "popq_rax_rax");
      push(K_RET, 0, 64'd3, "popq_rax_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
   endtask

   task automatic test_read_ports();
      exp_t e; logic [63:0] obs; logic [NP*AW-1:0] a;
      step(SAOK, IOPQ, 4'd14, 64'hE0E0, RNONE, 64'd0);
      idle();
      a = {4'd14, RNONE};
      rd_addr = a; #1;
      push(K_RD, 0, 64'd0, "read_rnone");
      push(K_RD, 1, 64'hE0E0, "read_top_reg");
      push(K_REG, 14, 64'hE0E0, "dump_top_reg");
      push(K_RET, 0, 64'd4, "read_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      @(negedge clk);
   endtask

   task automatic test_bypass();
      exp_t e; logic [63:0] obs; logic [NP*AW-1:0] a;
      a = {4'd5, 4'd2};
      rd_addr = a;
      drive(SAOK, IIRMOVQ, 4'd2, 64'h77, RNONE, 64'd0); #1;
`ifdef WB_BYPASS_EN
      push(K_RD, 0, 64'h77, "bypass_e_same_cycle");
`else
      push(K_RD, 0, 64'h1234, "no_bypass_same_cycle");
`endif
      push(K_REG, 2, 64'h1234, "dump_not_bypassed");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      @(negedge clk);
      drive(SAOK, IPOPQ, 4'd5, 64'h1, 4'd5, 64'h2); #1;
      push(K_RD, 0, 64'h77, "read_after_commit");
`ifdef WB_BYPASS_EN
      push(K_RD, 1, 64'h2, "bypass_m_priority");
`else
      push(K_RD, 1, 64'h0, "no_bypass_m");
`endif
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      @(negedge clk);
      idle(); #1;
      push(K_RD, 1, 64'h2, "read_m_after_commit");
      push(K_REG, 5, 64'h2, "dump_m_after_commit");
      push(K_RET, 0, 64'd6, "bypass_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      @(negedge clk);
   endtask

   task automatic test_counter();
      exp_t e; logic [63:0] obs;
      rst = 1'b1; #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         step(SAOK, ((i % 3) == 0) ? INOP : IOPQ, RNONE, 64'd0, RNONE, 64'd0);
      end
      idle();
      push(K_RET, 0, 64'd6, "count_10_minus_4_nop");
      push(K_RSAT, 0, 64'd6, "count3_below_sat");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      for (int i = 0; i < 3; i++) step(SAOK, IRRMOVQ, RNONE, 64'd0, RNONE, 64'd0);
      idle();
      push(K_RET, 0, 64'd9, "count_9");
      push(K_RSAT, 0, 64'd7, "count3_saturated");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      for (int i = 0; i < 2; i++) step(SAOK, IOPQ, RNONE, 64'd0, RNONE, 64'd0);
      idle();
      push(K_RET, 0, 64'd11, "count_11");
      push(K_RSAT, 0, 64'd7, "count3_held");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
   endtask

   task automatic test_halt();
      exp_t e; logic [63:0] obs;
      step(SAOK, IIRMOVQ, 4'd3, 64'h33, RNONE, 64'd0);
      step(SADR, IMRMOVQ, 4'd3, 64'h55, RNONE, 64'd0);
      idle();
      push(K_REG, 3, 64'h33, "halt_no_commit");
      push(K_HALT, 0, 64'd1, "halt_flag");
      push(K_HST, 0, 64'd3, "halt_stat_adr");
      push(K_RET, 0, 64'd12, "halt_retired");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
      step(SAOK, IIRMOVQ, 4'd3, 64'h99, 4'd7, 64'h98);
      step(SINS, IOPQ, 4'd3, 64'h11, RNONE, 64'd0);
      idle();
      push(K_REG, 3, 64'h33, "halted_e_ignored");
      push(K_REG, 7, 64'h0, "halted_m_ignored");
      push(K_HALT, 0, 64'd1, "halted_sticky");
      push(K_HST, 0, 64'd3, "halt_stat_frozen");
      push(K_RET, 0, 64'd12, "halted_retired_frozen");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.kind, e.idx); n_tests++;
         if (obs !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", e.name, e.idx, obs, e.exp); end
      end
   endtask

   initial begin
      rst = 1'b1;
      rd_addr = '0;
      idle();
      #12;
      test_reset();
      test_irmovq();
      test_popq();
      test_read_ports();
      test_bypass();
      test_counter();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
